// File: rtl/nexys_hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column strobing, whole-scan debounce, press strobes, 32-bit nibble entry register.
// Optional KEYPAD_AUTOREPEAT_EN: re-strobes a held key every REPEAT_SCANS full scans.
module nexys_hex_keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 250
) (
   input  logic        CLK100,
   input  logic        resetn,
   output logic [3:0]  COL,
   input  logic [3:0]  ROW,
   input  logic        clr,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_down,
   output logic [31:0] value
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] S_MAX = SW'(DEBOUNCE_SCANS);

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
      $error("nexys_hex_keypad_scanner: parameter out of range");
   end

   typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;
   typedef enum logic {RELEASED, HELD} state_t;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0:    key_map = 4'h1;
         4'h1:    key_map = 4'h2;
         4'h2:    key_map = 4'h3;
         4'h3:    key_map = 4'hA;
         4'h4:    key_map = 4'h4;
         4'h5:    key_map = 4'h5;
         4'h6:    key_map = 4'h6;
         4'h7:    key_map = 4'hB;
         4'h8:    key_map = 4'h7;
         4'h9:    key_map = 4'h8;
         4'hA:    key_map = 4'h9;
         4'hB:    key_map = 4'hC;
         4'hC:    key_map = 4'h0;
         4'hD:    key_map = 4'hF;
         4'hE:    key_map = 4'hE;
         default: key_map = 4'hD;
      endcase
   endfunction

   logic [3:0]    row_m, row_s;
   logic [CW-1:0] cnt;
   logic [1:0]    col_idx;
   logic [1:0]    acc_n;
   logic [3:0]    acc_code;
   res_t          cand_res;
   logic [3:0]    cand_code;
   logic [SW-1:0] stable;
   logic          scan_done;
   state_t        state, state_n;
   logic [3:0]    code_n;
   logic          valid_n;
   logic [31:0]   value_n;

   logic [3:0] low;
   logic [2:0] col_cnt, sum;
   logic [1:0] col_min, tot_n, row_idx;
   logic [3:0] new_code, scan_code;
   res_t       scan_res;

   assign COL      = ~(4'b0001 << col_idx);
   assign key_down = (state == HELD);
   assign low      = ~row_s;

   // acc_n counts low row bits seen so far this scan, saturating at 2 (= "many").
   always_comb begin
      col_cnt = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
      row_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (low[i]) row_idx = 2'(i);
      end
      col_min   = (col_cnt >= 3'd2) ? 2'd2 : col_cnt[1:0];
      sum       = {1'b0, acc_n} + {1'b0, col_min};
      tot_n     = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      new_code  = (acc_n == 2'd0 && col_cnt == 3'd1) ? key_map(row_idx, col_idx) : acc_code;
      scan_res  = (tot_n == 2'd0) ? RES_NONE : ((tot_n == 2'd1) ? RES_SINGLE : RES_MULTI);
      scan_code = (scan_res == RES_SINGLE) ? new_code : 4'h0;
   end

   always_ff @(posedge CLK100) begin
      if (!resetn) begin
         row_m     <= 4'hF;
         row_s     <= 4'hF;
         cnt       <= '0;
         col_idx   <= 2'd0;
         acc_n     <= 2'd0;
         acc_code  <= 4'h0;
         cand_res  <= RES_NONE;
         cand_code <= 4'h0;
         stable    <= '0;
         scan_done <= 1'b0;
      end else begin
         row_m     <= ROW;
         row_s     <= row_m;
         scan_done <= 1'b0;
         if (cnt == TC) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            if (col_idx == 2'd3) begin
               acc_n     <= 2'd0;
               acc_code  <= 4'h0;
               scan_done <= 1'b1;
               if (scan_res == cand_res && scan_code == cand_code) begin
                  if (stable != S_MAX) stable <= stable + SW'(1);
               end else begin
                  cand_res  <= scan_res;
                  cand_code <= scan_code;
                  stable    <= SW'(1);
               end
            end else begin
               acc_n    <= tot_n;
               acc_code <= new_code;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_SCANS + 1);
   logic [RW-1:0] rep_cnt, rep_n;
`endif

   logic deb_single, deb_none, emit;

   always_comb begin
      state_n    = state;
      valid_n    = 1'b0;
      code_n     = key_code;
      value_n    = value;
      emit       = 1'b0;
      deb_single = scan_done && cand_res == RES_SINGLE && stable == S_MAX;
      deb_none   = scan_done && cand_res == RES_NONE && stable == S_MAX;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_n      = rep_cnt;
`endif
      case (state)
         RELEASED: begin
            if (deb_single) begin
               state_n = HELD;
               emit    = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
               rep_n   = '0;
`endif
            end
         end
         HELD: begin
            if (deb_none) begin
               state_n = RELEASED;
`ifdef KEYPAD_AUTOREPEAT_EN
               rep_n   = '0;
            end else if (scan_done) begin
               if (cand_res == RES_SINGLE && cand_code == key_code) begin
                  if (rep_cnt == RW'(REPEAT_SCANS - 1)) begin
                     emit  = 1'b1;
                     rep_n = '0;
                  end else begin
                     rep_n = rep_cnt + RW'(1);
                  end
               end else begin
                  rep_n = '0;
               end
`endif
            end
         end
         default: state_n = RELEASED;
      endcase
      if (emit) begin
         valid_n = 1'b1;
         code_n  = cand_code;
         value_n = {value[27:0], cand_code};
      end
      // clr wins over a same-cycle shift; the strobe itself still goes out.
      if (clr) value_n = 32'h0;
   end

   always_ff @(posedge CLK100) begin
      if (!resetn) begin
         state     <= RELEASED;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         value     <= 32'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         state     <= state_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         value     <= value_n;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt   <= rep_n;
`endif
      end
   end

endmodule

// File: doc/nexys_hex_keypad_scanner.md
Name: nexys_hex_keypad_scanner

Overview:
Input-side counterpart of the board 7-segment scan driver, for a 4x4 hex keypad on a Nexys Pmod port (KYPD layout).
- Drives active-low column strobes one at a time and samples the active-low row returns.
- Debounces whole-keypad scan results and emits a single-cycle strobe per key press.
- Shifts each accepted nibble into a 32-bit entry register, which feeds WD3/address values into the register-file board wrapper in place of raw switches.

Parameters:
SCAN_DIV, 100000, clock cycles per column strobe period (1 ms at 100 MHz); must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; must be >= 1
REPEAT_SCANS, 250, full scans between auto-repeat strobes (used only with KEYPAD_AUTOREPEAT_EN)

Ports:
CLK100  input  1  system clock, 100 MHz
resetn  input  1  reset, synchronous, active-low
COL  output  4  column strobes, active-low, exactly one bit low at any time
ROW  input  4  row returns, active-low (pulled up on board), asynchronous
clr  input  1  synchronous clear of value
key_code  output  4  hex code of last accepted key
key_valid  output  1  one-cycle strobe when a key is accepted
key_down  output  1  high while an accepted key is considered held
value  output  32  entry register; each accepted key shifts in as low nibble

Behaviour:
- ROW passes through a 2-flop synchronizer before any use.
- Column counter runs 0..SCAN_DIV-1. At terminal count, COL rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Synchronized ROW is sampled on the terminal-count cycle of each column, before rotation.
- Key map (row r = ROW bit, column c = COL bit):
  - r0: c0=1, c1=2, c2=3, c3=A
  - r1: c0=4, c1=5, c2=6, c3=B
  - r2: c0=7, c1=8, c2=9, c3=C
  - r3: c0=0, c1=F, c2=E, c3=D
- Scan result is formed at the column-3 sample. It is one of:
  - NONE: no low row bits in any column
  - SINGLE(code): exactly one low bit in the whole scan
  - MULTI: more than one low bit
- Debounce:
  - If the scan result equals the previous result (including the code), stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise stable count is set to 1 and the result becomes the new candidate.
- FSM states: RELEASED, HELD.
  - RELEASED -> HELD: when the candidate is SINGLE and stable count reaches DEBOUNCE_SCANS.
    - key_valid = 1 for exactly one cycle (the cycle after the column-3 sample).
    - key_code = code, key_down = 1.
    - value = {value[27:0], code}.
  - HELD -> RELEASED: when the candidate is NONE and stable count reaches DEBOUNCE_SCANS; key_down = 0. No strobe on release.
  - MULTI never causes acceptance.
  - In HELD, MULTI or a different SINGLE does not release or re-accept. Only a debounced NONE exits HELD.
- clr:
  - value = 0 on any cycle clr = 1.
  - clr has priority over a same-cycle shift: the key is still strobed on key_code/key_valid but is not shifted into value.
- key_code and value hold between events.
- Reset (resetn = 0 at a CLK100 edge):
  - COL = 1110, column counter = 0, synchronizer = 1111, candidate = NONE, stable count = 0, state RELEASED.
  - key_code = 0, key_valid = 0, key_down = 0, value = 0.
  - Reset mid-scan or mid-debounce discards all progress. After reset a held key needs a full DEBOUNCE_SCANS again.
- Press-to-strobe latency for a clean press present from the start of a scan: DEBOUNCE_SCANS*4*SCAN_DIV cycles, plus 1.

Optional Feature:
KEYPAD_AUTOREPEAT_EN:
- Defined: in HELD with the candidate still SINGLE equal to key_code, a repeat counter counts full scans.
  - Each time it reaches REPEAT_SCANS, key_valid pulses and the same code shifts into value again; the counter then restarts.
  - Counter is cleared on entering HELD and on any non-matching scan.
- Undefined: no repeat logic; exactly one strobe per press.

Test Plan:
All tests use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan = 16 cycles. The keypad model drives ROW[r] low while key (r,c) is pressed and COL[c] = 0.
- Reset then idle 200 cycles -> COL cycles 1110, 1101, 1011, 0111 every 4 cycles; key_valid never 1; value = 0.
- Press r1c2 ("6") aligned to scan start -> single key_valid pulse 33 cycles later; key_code = 6, key_down = 1, value = 0x00000006.
- Press 1, 2, 3, A, then 5 with releases between (each >= 2 scans) -> value = 0x000123A5, five strobes total.
- Press 7 with 2-cycle bounce glitches inside each scan for 3 scans, then stable -> exactly one strobe, code 7. Release with bounce -> key_down falls only after 2 clean NONE scans.
- Hold r0c0 and r0c1 together -> no strobe. Hold 9, then add 4 while held -> no second strobe, key_down stays 1. Assert clr coincident with an accept strobe -> value = 0, key_code updated.
- Macro defined, REPEAT_SCANS=3, hold "E" for 12 scans after acceptance -> 4 extra strobes; value low nibbles all E.
